// File: rtl/des_pkg.sv
// DES constants, permutation tables and helpers.
// Shared by the iterative encrypt engine and the decrypt datapath.
package des_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } des_state_e;

  // Bit r set -> round r rotates C/D by one, else by two.
  localparam logic [15:0] SHIFT_ONE = 16'h8103;

  localparam byte unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam byte unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam byte unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam byte unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam byte unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam byte unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Indexed [box][row*16 + col].
  localparam byte unsigned SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  // Table entries are 1-based DES bit numbers, bit 1 = MSB.
  function automatic logic [63:0] des_ip(input logic [63:0] v);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[63-i] = v[64-int'(IP_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] v);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[63-i] = v[64-int'(FP_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] v);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[47-i] = v[32-int'(E_T[i])];
    return o;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] v);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[31-i] = v[32-int'(P_T[i])];
    return o;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] v);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[55-i] = v[64-int'(PC1_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] v);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[47-i] = v[56-int'(PC2_T[i])];
    return o;
  endfunction

  function automatic logic des_one_shift(input logic [3:0] rnd);
    return SHIFT_ONE[rnd];
  endfunction

  function automatic logic [27:0] des_rotl28(
    input logic [27:0] v,
    input logic        one
  );
    return one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
  endfunction

endpackage

// File: rtl/des_feistel_f.sv
// DES round function f(R, K): expand, key mix, S-boxes, P permutation.
// Purely combinational.
module des_feistel_f
  import des_pkg::*;
(
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] f_o
);

  logic [47:0] x;
  logic [31:0] s_out;
  logic [5:0]  six;

  always_comb begin
    x     = des_e(r_i) ^ k_i;
    s_out = '0;
    six   = '0;
    for (int s = 0; s < 8; s++) begin
      six = x[47-6*s -: 6];
      // Outer bits pick the row, inner four the column.
      s_out[31-4*s -: 4] = SBOX[s][{six[5], six[0], six[4:1]}][3:0];
    end
    f_o = des_p(s_out);
  end

endmodule

// File: rtl/des_encrypt_iter.sv
// Iterative DES encryptor: one Feistel round per clock, keys
// derived on the fly from a rotating C/D pair.
module des_encrypt_iter
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [63:0] PLAIN_TEXT,
  input  logic [63:0] KEY,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [63:0] CIPHER_TEXT,
  output logic        BUSY
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  des_state_e  state_q, state_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] kc_q, kc_d, kd_q, kd_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [63:0] ct_q, ct_d;
  logic        ov_q, ov_d;

  logic        one_sh;
  logic [27:0] kc_rot, kd_rot;
  logic [47:0] sub_key;
  logic [31:0] f_out, r_new;
  logic [63:0] ip_blk;
  logic [55:0] pc1_key;

  assign one_sh  = des_one_shift(rnd_q);
  assign kc_rot  = des_rotl28(kc_q, one_sh);
  assign kd_rot  = des_rotl28(kd_q, one_sh);
  assign sub_key = des_pc2({kc_rot, kd_rot});
  assign r_new   = l_q ^ f_out;
  assign ip_blk  = des_ip(PLAIN_TEXT);
  assign pc1_key = des_pc1(KEY);

  des_feistel_f u_f (
    .r_i (r_q),
    .k_i (sub_key),
    .f_o (f_out)
  );

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    kc_d    = kc_q;
    kd_d    = kd_q;
    rnd_d   = rnd_q;
    ct_d    = ct_q;
    ov_d    = ov_q;
    unique case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          l_d     = ip_blk[63:32];
          r_d     = ip_blk[31:0];
          kc_d    = pc1_key[55:28];
          kd_d    = pc1_key[27:0];
          rnd_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        kc_d  = kc_rot;
        kd_d  = kd_rot;
        l_d   = r_q;
        r_d   = r_new;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          // Final round skips the swap: output is {R16, L16}.
          ct_d    = des_fp({r_new, r_q});
          ov_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (OUT_READY) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      kc_q    <= '0;
      kd_q    <= '0;
      rnd_q   <= '0;
      ct_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      kc_q    <= kc_d;
      kd_q    <= kd_d;
      rnd_q   <= rnd_d;
      ct_q    <= ct_d;
      ov_q    <= ov_d;
    end
  end

  assign IN_READY    = (state_q == S_IDLE) && !rst;
  assign BUSY        = (state_q == S_ROUND);
  assign OUT_VALID   = ov_q;
  assign CIPHER_TEXT = ct_q;

endmodule

// File: tb/tb_des_encrypt_iter.sv
// Bench for des_encrypt_iter: known-answer table, handshake corner
// cases, and a random round-trip run through a scoreboard.
module tb_des_encrypt_iter;
  import des_pkg::*;

  localparam logic [63:0] STD_K = 64'h133457799BBCDFF1;
  localparam logic [63:0] STD_P = 64'h0123456789ABCDEF;
  localparam logic [63:0] STD_C = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] pt;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] cipher_text;
  logic        busy;

  always #5 clk = ~clk;

  des_encrypt_iter #(.NUM_ROUNDS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .IN_VALID    (in_valid),
    .IN_READY    (in_ready),
    .PLAIN_TEXT  (pt),
    .KEY         (key),
    .OUT_VALID   (out_valid),
    .OUT_READY   (out_ready),
    .CIPHER_TEXT (cipher_text),
    .BUSY        (busy)
  );

  typedef struct {
    logic [63:0] key;
    logic [63:0] pt;
    logic [63:0] ct;
  } sb_t;

  typedef struct {
    logic [63:0] key;
    logic [63:0] pt;
    logic [63:0] ct;
    string       nm;
  } kat_t;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  acc_l = 1'b0;
  sb_t sbq[$];
  int  acc_cyc[$];

  function automatic logic [31:0] model_f(
    input logic [31:0] r,
    input logic [47:0] k
  );
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    x = des_e(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b = x[47-6*i -: 6];
      s = {s[27:0], SBOX[i][{b[5], b[0], b[4:1]}][3:0]};
    end
    return des_p(s);
  endfunction

  function automatic logic [63:0] model_des(
    input logic [63:0] k,
    input logic [63:0] blk,
    input bit          dec
  );
    logic [47:0] ks [16];
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [63:0] x;
    logic [31:0] l, r, t;
    int          sh;
    cd = des_pc1(k);
    c  = cd[55:28];
    d  = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
      for (int j = 0; j < sh; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = des_pc2({c, d});
    end
    x = des_ip(blk);
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ model_f(r, ks[dec ? 15 - i : i]);
      l = t;
    end
    return des_fp({r, l});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, settle after the edge.
  task automatic tick();
    logic        a, o, r_s;
    logic [63:0] k, p, c;
    sb_t         e;
    @(negedge clk);
    a   = in_valid & in_ready;
    o   = out_valid & out_ready;
    r_s = rst;
    k   = key;
    p   = pt;
    c   = cipher_text;
    @(posedge clk);
    #1;
    cyc++;
    acc_l = (a === 1'b1) && (r_s !== 1'b1);
    if (r_s === 1'b1) begin
      sbq.delete();
    end else begin
      if (o === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got %h want none", c);
        end else begin
          e = sbq.pop_front();
          chk("sb_ct", c, e.ct);
          chk("sb_roundtrip", model_des(e.key, c, 1'b1), e.pt);
        end
      end
      if (a === 1'b1) begin
        e.key = k;
        e.pt  = p;
        e.ct  = model_des(k, p, 1'b0);
        sbq.push_back(e);
        acc_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic wait_accept(input string nm);
    int n;
    n     = 0;
    acc_l = 1'b0;
    while (!acc_l && n < 60) begin
      tick();
      n++;
    end
    chk({nm, "_accept"}, 64'(acc_l), 64'd1);
  endtask

  task automatic wait_out(input string nm, output bit rdy_seen);
    int n;
    n        = 0;
    rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
    end
    chk({nm, "_lat"}, 64'(n), 64'd16);
  endtask

  task automatic run_block(input logic [63:0] k, input logic [63:0] p,
                           input logic [63:0] c, input string nm);
    bit rs;
    key       = k;
    pt        = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_accept(nm);
    in_valid = 1'b0;
    key      = ~k;
    pt       = ~p;
    wait_out(nm, rs);
    chk({nm, "_ct"}, cipher_text, c);
    chk({nm, "_rdy_low"}, 64'(rs), 64'd0);
    tick();
    chk({nm, "_ov_drop"}, 64'(out_valid), 64'd0);
    chk({nm, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  kat_t        kats [3];
  logic [63:0] held, p2;
  bit          flag, rs;
  int          n;

  initial begin
    kats[0] = '{key: STD_K, pt: STD_P, ct: STD_C, nm: "std"};
    kats[1] = '{key: 64'h0, pt: 64'h0,
                ct: 64'h8CA64DE9C1B123A7, nm: "zero"};
    kats[2] = '{key: 64'h0101010101010101, pt: 64'h0,
                ct: 64'h8CA64DE9C1B123A7, nm: "parity"};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    key       = '0;
    pt        = '0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ct", cipher_text, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 3; i++)
      run_block(kats[i].key, kats[i].pt, kats[i].ct, kats[i].nm);

    // Back-pressure with ignored input pulses in DONE.
    key       = STD_K;
    pt        = STD_P;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    wait_accept("bp");
    in_valid = 1'b0;
    wait_out("bp", rs);
    held = cipher_text;
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      pt       = {$urandom(), $urandom()};
      tick();
      if (out_valid !== 1'b1 || cipher_text !== held ||
          busy !== 1'b0 || acc_l) flag = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_stable", 64'(flag), 64'd1);
    chk("bp_ct", held, STD_C);
    out_ready = 1'b1;
    tick();
    chk("bp_ov_drop", 64'(out_valid), 64'd0);
    chk("bp_rdy_back", 64'(in_ready), 64'd1);

    // Second block presented while busy must wait its turn.
    p2       = 64'hFEDCBA9876543210;
    key      = STD_K;
    pt       = STD_P;
    in_valid = 1'b1;
    wait_accept("busy1");
    pt = p2;
    wait_out("busy1", rs);
    chk("busy1_ct", cipher_text, STD_C);
    chk("busy1_no_accept", 64'(rs), 64'd0);
    n = cyc;
    wait_accept("busy2");
    chk("busy2_gap", 64'(cyc - n), 64'd2);
    in_valid = 1'b0;
    wait_out("busy2", rs);
    chk("busy2_ct", cipher_text, model_des(STD_K, p2, 1'b0));
    tick();

    // Reset at round 7 aborts the block.
    key      = STD_K;
    pt       = STD_P;
    in_valid = 1'b1;
    wait_accept("rmid");
    in_valid = 1'b0;
    repeat (7) tick();
    chk("rmid_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("rmid_ov", 64'(out_valid), 64'd0);
    chk("rmid_busy", 64'(busy), 64'd0);
    chk("rmid_ct", cipher_text, 64'd0);
    chk("rmid_rdy", 64'(in_ready), 64'd0);
    rst = 1'b0;
    flag = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid !== 1'b0) flag = 1'b1;
    end
    chk("rmid_no_out", 64'(flag), 64'd0);

    // Reset and IN_VALID together: reset wins.
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rst_vs_valid_busy", 64'(busy), 64'd0);
    chk("rst_vs_valid_sb", 64'(sbq.size()), 64'd0);
    run_block(STD_K, STD_P, STD_C, "after_rst");

    // Back-to-back random blocks.
    acc_cyc.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      key = {$urandom(), $urandom()};
      pt  = {$urandom(), $urandom()};
      wait_accept("rnd");
    end
    in_valid = 1'b0;
    n = 0;
    while (sbq.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("rnd_drain", 64'(sbq.size()), 64'd0);
    chk("rnd_count", 64'(acc_cyc.size()), 64'd20);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("rnd_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_encrypt_iter.md
Name: des_encrypt_iter

Overview:
- Iterative DES encryption engine: one Feistel round per clock, 16 rounds per block.
- Forward-direction counterpart of the combinational DES decrypt datapath.
- Round keys are generated on the fly with an incremental C/D shift schedule, not a 16-key array.
- Sits between a plaintext producer and a ciphertext consumer; valid/ready handshake on both sides.

Parameters:
- NUM_ROUNDS, 16, Feistel rounds per block. Fixed at 16 for standard DES; other values are for debug only.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- IN_VALID  input  1  PLAIN_TEXT and KEY are valid this cycle
- IN_READY  output  1  engine can accept a block
- PLAIN_TEXT  input  64  plaintext block, bit 63 = DES bit 1
- KEY  input  64  DES key including parity bits; parity bits ignored
- OUT_VALID  output  1  CIPHER_TEXT holds a completed block
- OUT_READY  input  1  consumer accepts CIPHER_TEXT
- CIPHER_TEXT  output  64  ciphertext, bit 63 = DES bit 1
- BUSY  output  1  high in ROUND state (status only)

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset rst is synchronous and active-high.
  - While rst is high at a clock edge: state=IDLE, IN_READY=0 during the reset cycle and 1 afterwards, OUT_VALID=0, BUSY=0, CIPHER_TEXT=0, round counter=0, L/R/C/D registers=0.
- FSM state IDLE:
  - IN_READY=1.
  - On IN_VALID & IN_READY:
    - L,R <= IP(PLAIN_TEXT).
    - C,D <= PC1(KEY).
    - rnd <= 0.
    - Go to ROUND.
- FSM state ROUND:
  - IN_READY=0, BUSY=1.
  - Each cycle:
    - C,D rotate left by SHIFT[rnd], where SHIFT = 1 for rnd in {0,1,8,15} and 2 otherwise.
    - K = PC2(rotated C,D), computed combinationally from the rotated value in the same cycle.
    - L <= R; R <= L ^ f(R,K); rnd <= rnd+1.
  - When rnd==NUM_ROUNDS-1:
    - CIPHER_TEXT <= FP({R_new, L_new}). This is the final swap, with R_new = L ^ f(R,K) and L_new = R.
    - OUT_VALID <= 1. Go to DONE.
- FSM state DONE:
  - OUT_VALID=1; CIPHER_TEXT stable.
  - On OUT_READY: OUT_VALID <= 0, go to IDLE.
  - IN_READY=0 in DONE; no overlap between blocks.
- Latency: a block accepted at edge t gives OUT_VALID high after edge t+16. That is 16 ROUND cycles, with the output registered on the last round. Throughput is at most one block per 18 cycles with OUT_READY tied high.
- Width rules:
  - C and D are 28 bits each; rotation wraps within 28 bits.
  - rnd is 4 bits; it wraps to 0 after the final round and is not used outside ROUND.
- Boundary conditions:
  - IN_VALID while busy or in DONE: ignored. Inputs are not sampled; the producer must hold until IN_READY.
  - OUT_READY asserted in IDLE or ROUND: no effect.
  - PLAIN_TEXT or KEY changing after acceptance: no effect, because both are captured at acceptance.
  - rst mid-round or in DONE: block aborted, outputs return to reset values next cycle, nothing emitted.
  - rst and IN_VALID in the same cycle: rst wins, block not accepted.
  - KEY parity bits (bit 0 of each byte): never affect the result.

Decomposition:
- Shared package des_pkg holds:
  - permutation tables IP, FP, E, P, PC1, PC2;
  - the 8 S-box tables;
  - the SHIFT schedule constant;
  - a state enum (IDLE, ROUND, DONE);
  - permutation helper functions.
- The decrypt path reuses this package.
- One sub-module: des_feistel_f, combinational f(R[31:0], K[47:0]) -> [31:0], covering E expansion, key XOR, S-boxes and P permutation.
- Top level holds the FSM, L/R/C/D registers, counter and handshake.

Test Plan:
- Standard vector: KEY=133457799BBCDFF1, PLAIN_TEXT=0123456789ABCDEF, OUT_READY=1 -> CIPHER_TEXT=85E813540F0AB405 with OUT_VALID high exactly 16 cycles after acceptance, IN_READY low until the cycle after output handshake.
- Zero vector: KEY=0000000000000000, PT=0000000000000000 -> 8CA64DE9C1B123A7. Repeat with KEY=0101010101010101 (parity bits only set) -> same ciphertext.
- Back-pressure: OUT_READY=0 for 10 cycles after OUT_VALID -> CIPHER_TEXT and OUT_VALID stable, IN_VALID pulses ignored; OUT_READY=1 -> OUT_VALID drops next cycle, IN_READY rises.
- Busy rejection: second block presented during ROUND with different PT -> not accepted; first block's result unchanged (85E813540F0AB405); second block accepted only once IN_READY=1 and produces its own correct result.
- Reset mid-operation: rst pulsed at round 7 -> OUT_VALID never asserts for that block, all outputs at reset values; a subsequent standard vector encrypts correctly.
- Round trip: 20 random key/PT pairs -> each CIPHER_TEXT, fed with the same KEY into the DES decrypt block, reproduces PLAIN_TEXT; back-to-back issue with OUT_READY=1 sustains one block per 18 cycles.
